// File: rtl/du_cmd_dispatch.sv
// Debug-unit command front end: pops a command byte, starts the matching
// sub-unit, lends it the UART path until done, then answers ACK or NAK.
//
// Ports:
//   clk, i_rst            clock, synchronous active-high reset
//   i_rx_done/i_rx_data   Rx FIFO not-empty level and head byte
//   i_tx_done             Tx byte-complete pulse
//   o_rd/o_wr/o_tx_start  UART FIFO read, write and Tx start strobes
//   o_wdata               UART Tx FIFO write data
//   o_start               one-hot sub-unit start pulse
//   i_unit_*              per-unit done and UART path requests
//   o_busy/o_sel/o_err    status: not idle, selected unit, unknown command
module du_cmd_dispatch #(
  parameter int unsigned NB_UART_DATA = 8,
  parameter int unsigned NB_UNITS     = 4,
  parameter logic [7:0]  CMD_0        = 8'h4C,
  parameter logic [7:0]  CMD_1        = 8'h44,
  parameter logic [7:0]  CMD_2        = 8'h52,
  parameter logic [7:0]  CMD_3        = 8'h53,
  parameter logic [7:0]  ACK_BYTE     = 8'h06,
  parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic                             i_rx_done,
  input  logic [NB_UART_DATA-1:0]          i_rx_data,
  input  logic                             i_tx_done,
  output logic                             o_rd,
  output logic                             o_wr,
  output logic                             o_tx_start,
  output logic [NB_UART_DATA-1:0]          o_wdata,
  output logic [NB_UNITS-1:0]              o_start,
  input  logic [NB_UNITS-1:0]              i_unit_done,
  input  logic [NB_UNITS-1:0]              i_unit_rd,
  input  logic [NB_UNITS-1:0]              i_unit_wr,
  input  logic [NB_UNITS-1:0]              i_unit_tx_start,
  input  logic [NB_UNITS*NB_UART_DATA-1:0] i_unit_wdata,
  output logic                             o_busy,
  output logic [1:0]                       o_sel,
  output logic                             o_err
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    START,
    RUN,
    ACK,
    ACK_WAIT
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [NB_UART_DATA-1:0] cmd_reg;
  logic [1:0]              sel_reg;
  logic [1:0]              sel_next;
  logic                    cmd_ld;
  logic                    sel_ld;
  logic [NB_UART_DATA-1:0] unit_wdata [NB_UNITS];

  for (genvar k = 0; k < NB_UNITS; k++) begin : g_wd
    assign unit_wdata[k] =
      i_unit_wdata[k*NB_UART_DATA +: NB_UART_DATA];
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cmd_reg <= '0;
      sel_reg <= '0;
    end else begin
      state <= state_next;
      if (cmd_ld) cmd_reg <= i_rx_data;
      if (sel_ld) sel_reg <= sel_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ld     = 1'b0;
    sel_ld     = 1'b0;
    sel_next   = sel_reg;
    o_rd       = 1'b0;
    o_wr       = 1'b0;
    o_tx_start = 1'b0;
    o_wdata    = '0;
    o_start    = '0;
    o_err      = 1'b0;
    case (state)
      IDLE: begin
        if (i_rx_done) begin
          o_rd       = 1'b1;
          cmd_ld     = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // Priority chain: lowest index wins on duplicate codes.
        sel_ld = 1'b1;
        if (cmd_reg == CMD_0)      sel_next = 2'd0;
        else if (cmd_reg == CMD_1) sel_next = 2'd1;
        else if (cmd_reg == CMD_2) sel_next = 2'd2;
        else if (cmd_reg == CMD_3) sel_next = 2'd3;
        else                       sel_ld   = 1'b0;
        if (sel_ld) begin
          state_next = START;
        end else begin
          o_wdata    = NAK_BYTE;
          o_wr       = 1'b1;
          o_tx_start = 1'b1;
          o_err      = 1'b1;
          state_next = ACK_WAIT;
        end
      end
      START: begin
        o_start[sel_reg] = 1'b1;
        state_next       = RUN;
      end
      RUN: begin
        o_rd       = i_unit_rd[sel_reg];
        o_wr       = i_unit_wr[sel_reg];
        o_tx_start = i_unit_tx_start[sel_reg];
        o_wdata    = unit_wdata[sel_reg];
        if (i_unit_done[sel_reg]) state_next = ACK;
      end
      ACK: begin
        o_wdata    = ACK_BYTE;
        o_wr       = 1'b1;
        o_tx_start = 1'b1;
        state_next = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (i_tx_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    o_busy = (state != IDLE);
    o_sel  = sel_reg;
    // Reset silences the whole UART path, including the Rx pop.
    o_rd = o_rd && !i_rst;
    if (i_rst) begin
      o_wr       = 1'b0;
      o_tx_start = 1'b0;
      o_wdata    = '0;
      o_start    = '0;
      o_err      = 1'b0;
      o_busy     = 1'b0;
      o_sel      = '0;
    end
  end

endmodule

// File: tb/tb_du_cmd_dispatch.sv
// Self-checking bench for du_cmd_dispatch: table of commands plus
// hand sequences for unit isolation, reset abort and back-to-back commands.
module tb_du_cmd_dispatch;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_tx_done;
  logic        o_rd, o_wr, o_tx_start, o_busy, o_err;
  logic [7:0]  o_wdata;
  logic [3:0]  o_start;
  logic [3:0]  i_unit_done, i_unit_rd, i_unit_wr, i_unit_tx_start;
  logic [31:0] i_unit_wdata;
  logic [1:0]  o_sel;

  int ncmp  = 0;
  int nfail = 0;
  int nack  = 0;

  du_cmd_dispatch dut (
    .clk(clk), .i_rst(i_rst),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done),
    .o_rd(o_rd), .o_wr(o_wr), .o_tx_start(o_tx_start),
    .o_wdata(o_wdata), .o_start(o_start),
    .i_unit_done(i_unit_done), .i_unit_rd(i_unit_rd),
    .i_unit_wr(i_unit_wr), .i_unit_tx_start(i_unit_tx_start),
    .i_unit_wdata(i_unit_wdata),
    .o_busy(o_busy), .o_sel(o_sel), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] start;
    logic       err;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_units();
    i_unit_done     = '0;
    i_unit_rd       = '0;
    i_unit_wr       = '0;
    i_unit_tx_start = '0;
    i_unit_wdata    = '0;
  endtask

  // issue a command from IDLE and land in RUN (or IDLE after NAK)
  task automatic run_vec(input vec_t v);
    i_rx_done = 1'b1;
    i_rx_data = v.cmd;
    #1;
    chk("idle_rd", o_rd, 1);
    chk("idle_busy", o_busy, 0);
    step();
    i_rx_done = 1'b0;
    #1;
    chk("dec_err", o_err, v.err);
    chk("dec_wr", o_wr, v.err);
    chk("dec_wdata", o_wdata, v.err ? 8'h15 : 8'h00);
    chk("dec_busy", o_busy, 1);
    step();
    chk("st_start", o_start, v.start);
    chk("st_sel", o_sel, v.sel);
    if (v.err) begin
      i_tx_done = 1'b1;
      step();
      i_tx_done = 1'b0;
      #1;
      chk("nak_idle", o_busy, 0);
    end else begin
      step();
      #1;
      chk("run_start0", o_start, 0);
      chk("run_busy", o_busy, 1);
    end
  endtask

  // unit sel finishes; check ACK and return to IDLE
  task automatic finish_unit(input logic [1:0] sel);
    i_unit_done[sel] = 1'b1;
    #1;
    step();
    i_unit_done = '0;
    #1;
    chk("ack_wr", o_wr, 1);
    chk("ack_txs", o_tx_start, 1);
    chk("ack_wdata", o_wdata, 8'h06);
    if (o_wr && o_wdata == 8'h06) nack++;
    step();
    #1;
    chk("ackw_wr", o_wr, 0);
    chk("ackw_busy", o_busy, 1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    #1;
    chk("done_busy", o_busy, 0);
  endtask

  initial begin
    vecs[0] = '{8'h4C, 4'b0001, 1'b0, 2'd0};
    vecs[1] = '{8'h44, 4'b0010, 1'b0, 2'd1};
    vecs[2] = '{8'h52, 4'b0100, 1'b0, 2'd2};
    vecs[3] = '{8'h53, 4'b1000, 1'b0, 2'd3};
    vecs[4] = '{8'h7A, 4'b0000, 1'b1, 2'd3};
    vecs[5] = '{8'h00, 4'b0000, 1'b1, 2'd3};
    vecs[6] = '{8'h44, 4'b0010, 1'b0, 2'd1};

    i_rst     = 1'b1;
    i_rx_done = 1'b1;
    i_rx_data = 8'h44;
    i_tx_done = 1'b0;
    clr_units();
    i_unit_wr = 4'hF;
    step();
    step();
    chk("rst_rd", o_rd, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_sel", o_sel, 0);
    chk("rst_start", o_start, 0);
    i_rx_done = 1'b0;
    clr_units();
    i_rst = 1'b0;
    step();
    chk("idle_rd0", o_rd, 0);
    chk("idle_busy0", o_busy, 0);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (!vecs[i].err) finish_unit(vecs[i].sel);
    end

    // unit isolation and foreign done, then reset abort
    run_vec('{8'h44, 4'b0010, 1'b0, 2'd1});
    i_unit_wr       = 4'b0110;
    i_unit_rd       = 4'b0100;
    i_unit_tx_start = 4'b0100;
    i_unit_wdata    = 32'h00CD_AB00;
    #1;
    chk("iso_wr", o_wr, 1);
    chk("iso_wdata", o_wdata, 8'hAB);
    chk("iso_rd", o_rd, 0);
    chk("iso_txs", o_tx_start, 0);
    clr_units();
    i_unit_done = 4'b1000;
    step();
    i_unit_done = '0;
    i_unit_wr   = 4'b0010;
    i_unit_wdata = 32'h0000_5A00;
    #1;
    chk("fdone_busy", o_busy, 1);
    chk("fdone_wr", o_wr, 1);
    chk("fdone_wdata", o_wdata, 8'h5A);
    i_rst       = 1'b1;
    i_unit_rd   = 4'b0010;
    i_unit_done = 4'b0010;
    #1;
    chk("ab_rd", o_rd, 0);
    chk("ab_wr", o_wr, 0);
    chk("ab_busy", o_busy, 0);
    chk("ab_wdata", o_wdata, 0);
    step();
    i_rst = 1'b0;
    clr_units();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ab_noack_wr", o_wr, 0);
      chk("ab_nostart", o_start, 0);
      chk("ab_idle", o_busy, 0);
      step();
    end

    // FIFO preloaded with 'R' then 'L'
    nack = 0;
    i_rx_done = 1'b1;
    i_rx_data = 8'h52;
    #1;
    chk("pre_rd", o_rd, 1);
    step();
    i_rx_data = 8'h4C;
    #1;
    chk("pre_dec_rd", o_rd, 0);
    step();
    chk("pre_start0", o_start, 4'b0100);
    step();
    #1;
    chk("pre_run_rd", o_rd, 0);
    i_unit_done[2] = 1'b1;
    step();
    i_unit_done = '0;
    #1;
    chk("pre_ack0", o_wdata, 8'h06);
    if (o_wr && o_wdata == 8'h06) nack++;
    step();
    #1;
    chk("pre_ackw_rd", o_rd, 0);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    #1;
    chk("b2b_rd", o_rd, 1);
    chk("b2b_busy", o_busy, 0);
    step();
    i_rx_done = 1'b0;
    step();
    chk("pre_start1", o_start, 4'b0001);
    step();
    finish_unit(2'd0);
    chk("pre_ack_count", nack, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
